// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with a fixed wait latency,
// byte-lane store commit and access-fault detection (range, alignment, store type).
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_store_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LOAD_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    function automatic logic [3:0] laneMask(input logic [1:0] storeType, input logic [1:0] lane);
        logic [3:0] mask;
        case (storeType)
            2'b00:   mask = 4'b0001 << lane;
            2'b01:   mask = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Right-justified store data replicated so every lane sees its own byte.
    function automatic logic [31:0] laneData(input logic [1:0] storeType, input logic [31:0] wdata);
        logic [31:0] data;
        case (storeType)
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic storeFault(input logic [1:0] storeType, input logic [1:0] lane);
        logic bad;
        case (storeType)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    stateT       state, stateNext;
    logic [3:0]  count, countNext;
    logic        capWe;
    logic [31:0] capAddr, capWdata;
    logic [1:0]  capType;
    logic        curWe;
    logic [31:0] curAddr, curWdata;
    logic [1:0]  curType;
    logic [31:0] off;
    logic        outOfRange, fault, commit, accept;
    logic [AW-1:0] index;
    logic [3:0]  wrMask;
    logic [31:0] wrData;
    logic        rspValidReg, rspErrReg;
    logic [31:0] rspRdataReg;
    logic [31:0] memArr [DEPTH_WORDS];

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rspValidReg;
    assign rsp_rdata = rspRdataReg;
    assign rsp_err   = rspErrReg;

    // Decode the request being committed: live inputs when LATENCY is 0, captured copy otherwise.
    always_comb begin
        if (state == IDLE) begin
            curWe    = req_we;
            curAddr  = req_addr;
            curWdata = req_wdata;
            curType  = req_store_type;
        end else begin
            curWe    = capWe;
            curAddr  = capAddr;
            curWdata = capWdata;
            curType  = capType;
        end
        off        = curAddr - BASE_ADDR;
        outOfRange = (off >= SPAN);
        index      = off[AW+1:2];
        fault      = outOfRange || (curWe && storeFault(curType, off[1:0]));
        wrMask     = laneMask(curType, off[1:0]);
        wrData     = laneData(curType, curWdata);
    end

    // Next-state and commit strobe.
    always_comb begin
        stateNext = state;
        countNext = count;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        stateNext = RESP;
                        commit    = 1'b1;
                    end else begin
                        stateNext = WAIT;
                        countNext = LOAD_CNT;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    stateNext = RESP;
                    commit    = 1'b1;
                end else begin
                    countNext = count - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = RESP;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Request capture at the accepting handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capWe    <= 1'b0;
            capAddr  <= 32'd0;
            capWdata <= 32'd0;
            capType  <= 2'b00;
        end else if (accept) begin
            capWe    <= req_we;
            capAddr  <= req_addr;
            capWdata <= req_wdata;
            capType  <= req_store_type;
        end
    end

    // Response registers: loaded on the commit edge, held until the core takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspValidReg <= 1'b0;
            rspRdataReg <= 32'd0;
            rspErrReg   <= 1'b0;
        end else if (commit) begin
            rspValidReg <= 1'b1;
            rspErrReg   <= fault;
            rspRdataReg <= (fault || curWe) ? 32'd0 : memArr[index];
        end else if (rspValidReg && rsp_ready) begin
            rspValidReg <= 1'b0;
            rspRdataReg <= 32'd0;
            rspErrReg   <= 1'b0;
        end
    end

    // Array write with byte lanes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && curWe && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (wrMask[b]) begin
                    memArr[index][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level memory model;
// a second instance with LATENCY=0 covers back-to-back throughput.
module tb_dmem_responder;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] SPAN = 32'd4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid, reqReady, reqWe, rspValid, rspReady, rspErr;
    logic [31:0] reqAddr, reqWdata, rspRdata;
    logic [1:0]  reqType;
    logic        d0Valid, d0Ready, d0We, d0RspValid, d0RspReady, d0Err;
    logic [31:0] d0Addr, d0Wdata, d0Rdata;
    logic [1:0]  d0Type;

    logic [7:0]  mb [0:63];
    logic [31:0] w0 [0:1];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_store_type(reqType),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata), .rsp_err(rspErr)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .rst(rst), .req_valid(d0Valid), .req_ready(d0Ready), .req_we(d0We),
        .req_addr(d0Addr), .req_wdata(d0Wdata), .req_store_type(d0Type),
        .rsp_valid(d0RspValid), .rsp_ready(d0RspReady), .rsp_rdata(d0Rdata), .rsp_err(d0Err)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: what a request should return, from byte addresses and the byte model.
    function automatic void expectOf(input logic we, input logic [31:0] addr, input logic [1:0] st,
                                     output logic [31:0] d, output logic e);
        int  o;
        int  w;
        bit  outside;
        bit  bad;
        outside = (addr < BASE) || (addr >= BASE + SPAN);
        bad = 1'b0;
        if (we) begin
            case (st)
                2'd0:    bad = 1'b0;
                2'd1:    bad = (addr % 2 != 0);
                2'd2:    bad = (addr % 4 != 0);
                default: bad = 1'b1;
            endcase
        end
        e = outside || bad;
        d = 32'd0;
        if (!e && !we) begin
            o = int'(addr - BASE);
            w = o - (o % 4);
            d = {mb[w+3], mb[w+2], mb[w+1], mb[w]};
        end
    endfunction

    function automatic void commitModel(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] st);
        int o;
        o = int'(addr - BASE);
        mb[o] = wd[7:0];
        if (st != 2'd0) mb[o+1] = wd[15:8];
        if (st == 2'd2) begin
            mb[o+2] = wd[23:16];
            mb[o+3] = wd[31:24];
        end
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] st, input int hold);
        logic [31:0] expData;
        logic        expErr;
        int          n;
        expectOf(we, addr, st, expData, expErr);
        reqWe = we; reqAddr = addr; reqWdata = wdata; reqType = st;
        reqValid = 1'b1; rspReady = 1'b1;
        n = 0;
        while (!reqReady && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkEq("acceptReady", {31'd0, reqReady}, 32'd1);
        @(posedge clk); #1;
        n = 0;
        while (!rspValid && n < 40) begin
            reqValid = 1'($urandom_range(0, 1));
            reqAddr = $urandom; reqWdata = $urandom; reqWe = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        checkEq("latency", n, LAT);
        checkEq("rdata", rspRdata, expData);
        checkEq("err", {31'd0, rspErr}, {31'd0, expErr});
        rspReady = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            reqValid = 1'($urandom_range(0, 1));
            reqAddr = $urandom; reqWdata = $urandom; reqType = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            checkEq("holdValid", {31'd0, rspValid}, 32'd1);
            checkEq("holdReqReady", {31'd0, reqReady}, 32'd0);
            checkEq("holdData", rspRdata, expData);
            checkEq("holdErr", {31'd0, rspErr}, {31'd0, expErr});
        end
        reqValid = 1'b0; rspReady = 1'b1;
        @(posedge clk); #1;
        checkEq("doneValid", {31'd0, rspValid}, 32'd0);
        checkEq("doneIdle", {31'd0, reqReady}, 32'd1);
        if (we && !expErr) commitModel(addr, wdata, st);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] expData;
        logic [31:0] badAddr [0:4];
        badAddr[0] = BASE - 32'd4; badAddr[1] = BASE + SPAN; badAddr[2] = 32'hFFFF_FFFC;
        badAddr[3] = 32'd0;        badAddr[4] = BASE - 32'd1;
        rst = 1'b1;
        reqValid = 1'b0; reqWe = 1'b0; reqAddr = 32'd0; reqWdata = 32'd0; reqType = 2'd0; rspReady = 1'b0;
        d0Valid = 1'b0; d0We = 1'b0; d0Addr = 32'd0; d0Wdata = 32'd0; d0Type = 2'd0; d0RspReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEq("rstReqReady", {31'd0, reqReady}, 32'd0);
        checkEq("rstRspValid", {31'd0, rspValid}, 32'd0);
        checkEq("rstRdata", rspRdata, 32'd0);
        checkEq("rstErr", {31'd0, rspErr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkEq("postRstReady", {31'd0, reqReady}, 32'd1);

        for (int w = 0; w < 16; w++) txn(1'b1, BASE + 32'(4 * w), $urandom, 2'd2, 0);

        txn(1'b1, 32'h2004, 32'hDEAD_BEEF, 2'd2, 0);
        txn(1'b0, 32'h2004, 32'd0, 2'd0, 0);
        txn(1'b1, 32'h2008, 32'h1122_3344, 2'd2, 0);
        txn(1'b1, 32'h200A, 32'h0000_00AA, 2'd0, 0);
        txn(1'b1, 32'h2008, 32'h0000_5566, 2'd1, 0);
        expectOf(1'b0, 32'h2008, 2'd0, expData, rspErr);
        checkEq("laneMerge", expData, 32'h11AA_5566);
        txn(1'b0, 32'h2008, 32'd0, 2'd0, 0);

        txn(1'b1, 32'h2001, 32'hFFFF_FFFF, 2'd1, 0);
        txn(1'b1, 32'h2002, 32'hFFFF_FFFF, 2'd2, 0);
        txn(1'b1, 32'h2000, 32'hFFFF_FFFF, 2'd3, 0);
        txn(1'b0, 32'h1FFC, 32'd0, 2'd0, 0);
        txn(1'b0, BASE + SPAN, 32'd0, 2'd0, 0);
        txn(1'b0, 32'h2000, 32'd0, 2'd0, 0);

        txn(1'b0, 32'h2008, 32'd0, 2'd0, 5);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) a = badAddr[$urandom_range(0, 4)];
            else a = BASE + 32'($urandom_range(0, 63));
            txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        reqWe = 1'b1; reqAddr = 32'h2010; reqWdata = 32'h1234_5678; reqType = 2'd2; reqValid = 1'b1;
        rspReady = 1'b0;
        checkEq("abortAcceptReady", {31'd0, reqReady}, 32'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkEq("abortReadyLow", {31'd0, reqReady}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkEq("abortNoRsp", {31'd0, rspValid}, 32'd0);
        end
        txn(1'b0, 32'h2010, 32'd0, 2'd0, 0);

        d0Valid = 1'b1; d0RspReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkEq("l0Ready", {31'd0, d0Ready}, 32'd1);
            checkEq("l0Idle", {31'd0, d0RspValid}, 32'd0);
            d0We = (i < 2); d0Type = 2'd2; d0Wdata = $urandom;
            d0Addr = BASE + 32'(4 * (i % 2));
            if (i < 2) w0[i] = d0Wdata;
            expData = (i < 2) ? 32'd0 : w0[i % 2];
            @(posedge clk); #1;
            checkEq("l0Valid", {31'd0, d0RspValid}, 32'd1);
            checkEq("l0Busy", {31'd0, d0Ready}, 32'd0);
            checkEq("l0Data", d0Rdata, expData);
            checkEq("l0Err", {31'd0, d0Err}, 32'd0);
            d0Addr = $urandom; d0We = 1'b1; d0Wdata = $urandom; d0Type = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        d0Valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
